// File: rtl/robot_pkg.sv
// Shared types and defaults for the robot obstacle scheduler.
// Build option ROBOT_SCHED_FRONT_PRIO_EN gives sensor 0 absolute priority.
package robot_pkg;

    localparam int unsigned DATA_IN_WIDTH = 16;
    localparam logic [DATA_IN_WIDTH-1:0] MIN_DIST = 16'd50;

    typedef logic [DATA_IN_WIDTH-1:0] dist_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CMP    = 2'd1,
        UPDATE = 2'd2
    } sched_state_t;

endpackage

// File: rtl/robot_obs_scheduler_if.sv
// Sensor-request and alarm signals between the sensors/motion side and the scheduler.
// master = sensor/controller side, slave = scheduler.
interface robot_obs_scheduler_if #(
    parameter int unsigned NUM_SENSORS   = 4,
    parameter int unsigned DATA_IN_WIDTH = 16
);
    localparam int unsigned SRC_W = $clog2(NUM_SENSORS);

    logic [NUM_SENSORS-1:0]               req_valid;
    logic [NUM_SENSORS*DATA_IN_WIDTH-1:0] req_dist;
    logic [NUM_SENSORS-1:0]               req_ready;
    logic [NUM_SENSORS-1:0]               obs_flags;
    logic                                 alarm_flag;
    logic [SRC_W-1:0]                     alarm_src;
    logic                                 busy;

    modport master (
        output req_valid, req_dist,
        input  req_ready, obs_flags, alarm_flag, alarm_src, busy
    );

    modport slave (
        input  req_valid, req_dist,
        output req_ready, obs_flags, alarm_flag, alarm_src, busy
    );

endinterface

// File: rtl/robot_rr_arbiter.sv
// Combinational round-robin grant: first valid requester after ptr_i, wrapping.
// With ROBOT_SCHED_FRONT_PRIO_EN, a valid sensor 0 always wins.
module robot_rr_arbiter #(
    parameter int unsigned NUM_SENSORS = 4
) (
    input  logic [NUM_SENSORS-1:0]         valid_i,
    input  logic [$clog2(NUM_SENSORS)-1:0] ptr_i,
    output logic [NUM_SENSORS-1:0]         grant_c_o
);
    localparam int unsigned PW = $clog2(NUM_SENSORS);

    logic [PW-1:0] cand;
    logic          found;

    always_comb begin
        grant_c_o = '0;
        cand      = '0;
        found     = 1'b0;
`ifdef ROBOT_SCHED_FRONT_PRIO_EN
        if (valid_i[0]) begin
            grant_c_o[0] = 1'b1;
            found        = 1'b1;
        end
`endif
        for (int unsigned k = 1; k <= NUM_SENSORS; k++) begin
            cand = PW'((32'(ptr_i) + k) % NUM_SENSORS);
            if (!found && valid_i[cand]) begin
                grant_c_o[cand] = 1'b1;
                found           = 1'b1;
            end
        end
    end

endmodule

// File: rtl/robot_obs_scheduler.sv
// Time-shares one registered dist < MIN_DIST comparator across NUM_SENSORS sensors,
// keeps per-sensor obstacle flags and a debounced alarm. Option: ROBOT_SCHED_FRONT_PRIO_EN.
module robot_obs_scheduler #(
    parameter int unsigned               NUM_SENSORS   = 4,
    parameter int unsigned               DATA_IN_WIDTH = robot_pkg::DATA_IN_WIDTH,
    parameter logic [DATA_IN_WIDTH-1:0]  MIN_DIST      = DATA_IN_WIDTH'(robot_pkg::MIN_DIST),
    parameter int unsigned               CLEAR_CYCLES  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    robot_obs_scheduler_if.slave  sched_if
);
    import robot_pkg::*;

    localparam int unsigned SRC_W   = $clog2(NUM_SENSORS);
    localparam logic [7:0]  CLR_MAX = 8'(CLEAR_CYCLES);

    sched_state_t             state_q, state_d;
    logic [SRC_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [SRC_W-1:0]         idx_q, idx_d;
    logic [DATA_IN_WIDTH-1:0] dist_q, dist_d;
    logic                     obs_q, obs_d;
    logic [NUM_SENSORS-1:0]   flags_q, flags_d;
    logic                     alarm_q, alarm_d;
    logic [SRC_W-1:0]         src_q, src_d;
    logic [7:0]               clr_q, clr_d;
    logic                     busy_q, busy_d;
    logic [NUM_SENSORS-1:0]   grant_c;
    logic [NUM_SENSORS-1:0]   req_ready_c;

    robot_rr_arbiter #(
        .NUM_SENSORS (NUM_SENSORS)
    ) u_arb (
        .valid_i   (sched_if.req_valid),
        .ptr_i     (rr_ptr_q),
        .grant_c_o (grant_c)
    );

    // Accept / compare / update sequencing; ready is only offered while idle.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        idx_d       = idx_q;
        dist_d      = dist_q;
        obs_d       = obs_q;
        flags_d     = flags_q;
        req_ready_c = '0;
        case (state_q)
            IDLE: begin
                req_ready_c = grant_c;
                for (int unsigned i = 0; i < NUM_SENSORS; i++) begin
                    if (grant_c[i]) begin
                        dist_d = sched_if.req_dist[i*DATA_IN_WIDTH +: DATA_IN_WIDTH];
                        idx_d  = SRC_W'(i);
                    end
                end
                if (|grant_c) state_d = CMP;
            end
            CMP: begin
                obs_d   = (dist_q < MIN_DIST);
                state_d = UPDATE;
            end
            UPDATE: begin
                flags_d[idx_q] = obs_q;
`ifdef ROBOT_SCHED_FRONT_PRIO_EN
                if (idx_q != '0) rr_ptr_d = idx_q;
`else
                rr_ptr_d = idx_q;
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // Alarm debounce and source encode, both looking at the registered flags.
    always_comb begin
        src_d   = '0;
        alarm_d = alarm_q;
        clr_d   = clr_q;
        for (int i = NUM_SENSORS - 1; i >= 0; i--) begin
            if (flags_q[i]) src_d = SRC_W'(i);
        end
        if (|flags_q) begin
            alarm_d = 1'b1;
            clr_d   = 8'd0;
        end else begin
            if (clr_q != CLR_MAX)          clr_d   = clr_q + 8'd1;
            if (clr_q == CLR_MAX - 8'd1)   alarm_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= SRC_W'(NUM_SENSORS - 1);
            idx_q    <= '0;
            dist_q   <= '0;
            obs_q    <= 1'b0;
            flags_q  <= '0;
            alarm_q  <= 1'b0;
            src_q    <= '0;
            clr_q    <= 8'd0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            idx_q    <= idx_d;
            dist_q   <= dist_d;
            obs_q    <= obs_d;
            flags_q  <= flags_d;
            alarm_q  <= alarm_d;
            src_q    <= src_d;
            clr_q    <= clr_d;
            busy_q   <= busy_d;
        end
    end

    assign sched_if.req_ready  = req_ready_c;
    assign sched_if.obs_flags  = flags_q;
    assign sched_if.alarm_flag = alarm_q;
    assign sched_if.alarm_src  = src_q;
    assign sched_if.busy       = busy_q;

endmodule

// File: tb/tb_robot_obs_scheduler.sv
// Bench for robot_obs_scheduler: directed steps plus random traffic against a
// transaction-level model (slot timing, served-last pointer, alarm window).
module tb_robot_obs_scheduler;
    import robot_pkg::*;

    localparam int N   = 4;
    localparam int W   = DATA_IN_WIDTH;
    localparam int CLR = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    robot_obs_scheduler_if #(.NUM_SENSORS(N), .DATA_IN_WIDTH(W)) bus ();

    robot_obs_scheduler #(
        .NUM_SENSORS   (N),
        .DATA_IN_WIDTH (W),
        .MIN_DIST      (MIN_DIST),
        .CLEAR_CYCLES  (CLR)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sched_if (bus)
    );

    int errors = 0;
    int checks = 0;

    // model state
    int         n_edge      = 0;
    int         free_at     = 1;
    int         last_served = N - 1;
    int         last_nz     = -1000;
    int         exp_src     = 0;
    logic [N-1:0] mflags    = '0;
    bit         pend_v      = 0;
    int         pend_e      = 0;
    int         pend_idx    = 0;
    bit         pend_obs    = 0;

    int dut_acc;
    int dut_gnt[$];
    int dut_gnt_e[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v);
        int i;
`ifdef ROBOT_SCHED_FRONT_PRIO_EN
        if (v[0]) return 0;
`endif
        for (int k = 1; k <= N; k++) begin
            i = (last_served + k) % N;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] rnd_dist();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return W'(49);
            2:       return W'(50);
            3:       return '1;
            4:       return W'($urandom_range(0, 100));
            default: return W'($urandom);
        endcase
    endfunction

    // One clock: check ready before the edge, advance the model, check outputs after.
    task automatic cycle();
        logic [N-1:0] exp_rdy;
        logic [W-1:0] d;
        int g, e, src;
        bit any;
        exp_rdy = '0;
        g       = -1;
        dut_acc = -1;
        @(negedge clk);
        e = n_edge + 1;
        if (!rst && e >= free_at) begin
            g = pick(bus.req_valid);
            if (g >= 0) exp_rdy[g] = 1'b1;
        end
        if (!rst) begin
            chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
            for (int i = 0; i < N; i++) begin
                if (bus.req_ready[i] && bus.req_valid[i]) begin
                    dut_acc = i;
                    dut_gnt.push_back(i);
                    dut_gnt_e.push_back(e);
                end
            end
        end
        @(posedge clk);
        n_edge = e;
        if (rst) begin
            mflags      = '0;
            pend_v      = 0;
            free_at     = e + 1;
            last_served = N - 1;
            last_nz     = -1000;
            exp_src     = 0;
        end else begin
            any = 0;
            src = 0;
            for (int i = N - 1; i >= 0; i--) begin
                if (mflags[i]) begin any = 1; src = i; end
            end
            if (any) last_nz = e - 1;
            exp_src = src;
            if (pend_v && pend_e == e) begin
                mflags[pend_idx] = pend_obs;
                pend_v = 0;
            end
            if (g >= 0) begin
                d        = bus.req_dist[g*W +: W];
                pend_v   = 1;
                pend_e   = e + 2;
                pend_idx = g;
                pend_obs = (d < MIN_DIST);
                free_at  = e + 3;
`ifdef ROBOT_SCHED_FRONT_PRIO_EN
                if (g != 0) last_served = g;
`else
                last_served = g;
`endif
            end
        end
        #1;
        chk("obs_flags",  32'(bus.obs_flags),  32'(mflags));
        chk("alarm_flag", 32'(bus.alarm_flag), 32'(last_nz >= e - CLR));
        chk("alarm_src",  32'(bus.alarm_src),  32'(exp_src));
        chk("busy",       32'(bus.busy),       32'(e + 1 < free_at));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    // Present one sample, wait for its grant, return right after its flag update edge.
    task automatic send(input int s, input int d);
        int t;
        bus.req_valid[s]         = 1'b1;
        bus.req_dist[s*W +: W]   = W'(d);
        t = 0;
        do begin
            cycle();
            t++;
        end while (dut_acc != s && t < 30);
        chk("send_grant", 32'(dut_acc == s), 32'd1);
        bus.req_valid[s] = 1'b0;
        cycle();
        cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, nb, t, d1;
        bus.req_valid = '0;
        bus.req_dist  = '0;
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;

        // reset in the middle of a compare discards the sample
        bus.req_valid[1]     = 1'b1;
        bus.req_dist[W +: W] = W'(10);
        cycle();
        chk("t1_accept", 32'(dut_acc), 32'd1);
        bus.req_valid[1] = 1'b0;
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        cycle();
        chk("t1_flags", 32'(bus.obs_flags),  32'd0);
        chk("t1_alarm", 32'(bus.alarm_flag), 32'd0);
        chk("t1_ready", 32'(bus.req_ready),  32'd0);
        chk("t1_busy",  32'(bus.busy),       32'd0);
        cycle();
        cycle();
        chk("t1_noupd", 32'(bus.obs_flags),  32'd0);

        // single sensor latency
        send(2, 49);
        chk("t2_flag2", 32'(bus.obs_flags[2]), 32'd1);
        cycle();
        chk("t2_alarm", 32'(bus.alarm_flag), 32'd1);
        chk("t2_src",   32'(bus.alarm_src),  32'd2);

        // threshold boundaries
        send(0, 50);      chk("t3_eq_min",  32'(bus.obs_flags[0]), 32'd0);
        send(0, 49);      chk("t3_min_m1",  32'(bus.obs_flags[0]), 32'd1);
        send(0, 'hFFFF);  chk("t3_ones",    32'(bus.obs_flags[0]), 32'd0);
        send(0, 0);       chk("t3_zero",    32'(bus.obs_flags[0]), 32'd1);

        // debounce and restart
        do_reset();
        send(3, 10);
        send(3, 200);
        cnt = 0;
        while (bus.alarm_flag === 1'b1 && cnt < 20) begin cycle(); cnt++; end
        chk("t5_debounce", 32'(cnt), 32'(CLR));
        send(3, 10);
        send(3, 200);
        for (int i = 0; i < 4; i++) cycle();
        send(3, 10);
        chk("t5_redetect", 32'(bus.alarm_flag), 32'd1);
        send(3, 200);
        cnt = 0;
        while (bus.alarm_flag === 1'b1 && cnt < 20) begin cycle(); cnt++; end
        chk("t5_debounce2", 32'(cnt), 32'(CLR));

        // fairness with all sensors continuously valid
        do_reset();
        for (int i = 0; i < N; i++) bus.req_dist[i*W +: W] = W'(100);
        bus.req_valid = '1;
        dut_gnt.delete();
        dut_gnt_e.delete();
        for (int i = 0; i < 15; i++) cycle();
        bus.req_valid = '0;
        chk("t4_count", 32'(dut_gnt.size()), 32'd5);
        for (int i = 0; i < 5 && i < dut_gnt.size(); i++) begin
`ifdef ROBOT_SCHED_FRONT_PRIO_EN
            chk("t4_order", 32'(dut_gnt[i]), 32'd0);
`else
            chk("t4_order", 32'(dut_gnt[i]), 32'(i % N));
`endif
            if (i > 0) chk("t4_spacing", 32'(dut_gnt_e[i] - dut_gnt_e[i-1]), 32'd3);
        end
        for (int i = 0; i < 3; i++) cycle();

        // held request with changing data
        do_reset();
        send(1, 30);
        d1 = 10;
        bus.req_dist[W +: W] = W'(d1);
        bus.req_valid = '1;
        nb = 0;
        t  = 0;
        do begin
            cycle();
            t++;
            if (dut_acc >= 0 && dut_acc != 1) begin
                bus.req_valid[dut_acc] = 1'b0;
                nb++;
            end
            if (dut_acc != 1) begin
                d1 = ($urandom_range(0, 1) != 0) ? 10 : 200;
                bus.req_dist[W +: W] = W'(d1);
            end
        end while (dut_acc != 1 && t < 40);
        chk("t6_grant",   32'(dut_acc), 32'd1);
        chk("t6_waited",  32'(nb), 32'd3);
        bus.req_valid = '0;
        cycle();
        cycle();
        chk("t6_used", 32'(bus.obs_flags[1]), 32'(d1 < 50));

        // random traffic
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 79) == 0);
            cycle();
            if (dut_acc >= 0) bus.req_valid[dut_acc] = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (!bus.req_valid[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        bus.req_valid[i]       = 1'b1;
                        bus.req_dist[i*W +: W] = rnd_dist();
                    end
                end else if ($urandom_range(0, 3) == 0) begin
                    bus.req_dist[i*W +: W] = rnd_dist();
                end
            end
        end
        rst = 1'b0;
        bus.req_valid = '0;
        for (int i = 0; i < 14; i++) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
